// File: rtl/arm_pkg.sv
// arm_pkg: shared widths, forwarding selects and the ID/EXE control record.
package arm_pkg;
  localparam int EXE_CMD_W = 4;
  localparam int REG_W = 4;
  localparam logic [1:0] FWD_SEL_ID = 2'd0;
  localparam logic [1:0] FWD_SEL_WB = 2'd1;
  localparam logic [1:0] FWD_SEL_MEM = 2'd2;
  // DW-wide values sit beside this record in the top; a package type cannot follow a module parameter.
  typedef struct packed {
    logic valid;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dest;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic mem_r_en;
    logic mem_w_en;
    logic wb_en;
    logic b;
    logic s;
    logic imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0] status;
  } id_exe_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: RAW/load-use interlock decision for the instruction in ID.
module hazard_detect
  import arm_pkg::*;
(
  input  logic             valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             exe_valid,
  input  logic             exe_mem_r_en,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             forwarding_en,
  output logic             hazard
);
  logic exe_hit, mem_hit;
  assign exe_hit = exe_valid & ((exe_dest == src1) | (two_src & (exe_dest == src2)));
  assign mem_hit = mem_wb_en & ((mem_dest == src1) | (two_src & (mem_dest == src2)));
  // WB needs no check: the register file writes on the falling edge.
  assign hazard = valid & (forwarding_en ? exe_hit & exe_mem_r_en : (exe_hit & exe_wb_en) | mem_hit);
endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with hazard interlock and bubble counter.
module id_exe_stage_reg
  import arm_pkg::*;
#(
  parameter int DW = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 forwarding_en,
  input  logic                 id_valid,
  input  logic [DW-1:0]        id_pc,
  input  logic [DW-1:0]        id_val_rn,
  input  logic [DW-1:0]        id_val_rm,
  input  logic [REG_W-1:0]     id_src1,
  input  logic [REG_W-1:0]     id_src2,
  input  logic [REG_W-1:0]     id_dest,
  input  logic                 id_two_src,
  input  logic [EXE_CMD_W-1:0] id_exe_cmd,
  input  logic                 id_mem_r_en,
  input  logic                 id_mem_w_en,
  input  logic                 id_wb_en,
  input  logic                 id_b,
  input  logic                 id_s,
  input  logic                 id_imm,
  input  logic [11:0]          id_shift_operand,
  input  logic [23:0]          id_signed_imm_24,
  input  logic [3:0]           id_status,
  input  logic [REG_W-1:0]     mem_dest,
  input  logic                 mem_wb_en,
  output logic                 hazard_stall,
  output logic                 exe_valid,
  output logic [DW-1:0]        exe_pc,
  output logic [DW-1:0]        exe_val_rn,
  output logic [DW-1:0]        exe_val_rm,
  output logic [REG_W-1:0]     exe_src1,
  output logic [REG_W-1:0]     exe_src2,
  output logic [REG_W-1:0]     exe_dest,
  output logic [EXE_CMD_W-1:0] exe_exe_cmd,
  output logic                 exe_mem_r_en,
  output logic                 exe_mem_w_en,
  output logic                 exe_wb_en,
  output logic                 exe_b,
  output logic                 exe_s,
  output logic                 exe_imm,
  output logic [11:0]          exe_shift_operand,
  output logic [23:0]          exe_signed_imm_24,
  output logic [3:0]           exe_status,
  output logic [CNT_W-1:0]     bubble_count
);
  id_exe_t q, d;
  logic [DW-1:0] pc_q, val_rn_q, val_rm_q;
  logic hazard, bubble;
  hazard_detect u_hazard (
    .valid(id_valid),
    .src1(id_src1),
    .src2(id_src2),
    .two_src(id_two_src),
    .exe_valid(q.valid),
    .exe_mem_r_en(q.mem_r_en),
    .exe_wb_en(q.wb_en),
    .exe_dest(q.dest),
    .mem_wb_en(mem_wb_en),
    .mem_dest(mem_dest),
    .forwarding_en(forwarding_en),
    .hazard(hazard)
  );
  assign hazard_stall = hazard & ~flush;
  assign bubble = flush | hazard;
  assign d = '{
    valid: id_valid,
    src1: id_src1,
    src2: id_src2,
    dest: id_dest,
    exe_cmd: id_exe_cmd,
    mem_r_en: id_mem_r_en,
    mem_w_en: id_mem_w_en,
    wb_en: id_wb_en,
    b: id_b,
    s: id_s,
    imm: id_imm,
    shift_operand: id_shift_operand,
    signed_imm_24: id_signed_imm_24,
    status: id_status
  };
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      pc_q <= '0;
      val_rn_q <= '0;
      val_rm_q <= '0;
      bubble_count <= '0;
    end else if (!freeze) begin
      q <= bubble ? id_exe_t'('0) : d;
      pc_q <= bubble ? '0 : id_pc;
      val_rn_q <= bubble ? '0 : id_val_rn;
      val_rm_q <= bubble ? '0 : id_val_rm;
      if (hazard_stall && bubble_count != '1) bubble_count <= bubble_count + CNT_W'(1);
    end
  end
  assign exe_valid = q.valid;
  assign exe_pc = pc_q;
  assign exe_val_rn = val_rn_q;
  assign exe_val_rm = val_rm_q;
  assign exe_src1 = q.src1;
  assign exe_src2 = q.src2;
  assign exe_dest = q.dest;
  assign exe_exe_cmd = q.exe_cmd;
  assign exe_mem_r_en = q.mem_r_en;
  assign exe_mem_w_en = q.mem_w_en;
  assign exe_wb_en = q.wb_en;
  assign exe_b = q.b;
  assign exe_s = q.s;
  assign exe_imm = q.imm;
  assign exe_shift_operand = q.shift_operand;
  assign exe_signed_imm_24 = q.signed_imm_24;
  assign exe_status = q.status;
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: random + directed scoreboard bench against an instruction-level model.
module tb_id_exe_stage_reg;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic freeze = 0, flush = 0, forwarding_en = 0, id_valid = 0, id_two_src = 0, mem_wb_en = 0;
  logic [31:0] id_pc = 0, id_val_rn = 0, id_val_rm = 0;
  logic [3:0] id_src1 = 0, id_src2 = 0, id_dest = 0, id_exe_cmd = 0, id_status = 0, mem_dest = 0;
  logic id_mem_r_en = 0, id_mem_w_en = 0, id_wb_en = 0, id_b = 0, id_s = 0, id_imm = 0;
  logic [11:0] id_shift_operand = 0;
  logic [23:0] id_signed_imm_24 = 0;
  logic hazard_stall, exe_valid, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s, exe_imm;
  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic [3:0] exe_src1, exe_src2, exe_dest, exe_exe_cmd, exe_status;
  logic [11:0] exe_shift_operand;
  logic [23:0] exe_signed_imm_24;
  logic [15:0] bubble_count;
  logic s_stall, s_valid, s_mem_r_en, s_mem_w_en, s_wb_en, s_b, s_s, s_imm;
  logic [31:0] s_pc, s_val_rn, s_val_rm;
  logic [3:0] s_src1, s_src2, s_dest, s_exe_cmd, s_status;
  logic [11:0] s_shift_operand;
  logic [23:0] s_signed_imm_24;
  logic [1:0] s_count;

  id_exe_stage_reg #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .forwarding_en(forwarding_en),
    .id_valid(id_valid), .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest), .id_two_src(id_two_src),
    .id_exe_cmd(id_exe_cmd), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_wb_en(id_wb_en), .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
    .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
    .id_status(id_status), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .hazard_stall(hazard_stall), .exe_valid(exe_valid), .exe_pc(exe_pc),
    .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm), .exe_src1(exe_src1),
    .exe_src2(exe_src2), .exe_dest(exe_dest), .exe_exe_cmd(exe_exe_cmd),
    .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en), .exe_wb_en(exe_wb_en),
    .exe_b(exe_b), .exe_s(exe_s), .exe_imm(exe_imm), .exe_shift_operand(exe_shift_operand),
    .exe_signed_imm_24(exe_signed_imm_24), .exe_status(exe_status), .bubble_count(bubble_count)
  );

  id_exe_stage_reg #(.DW(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .forwarding_en(forwarding_en),
    .id_valid(id_valid), .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest), .id_two_src(id_two_src),
    .id_exe_cmd(id_exe_cmd), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_wb_en(id_wb_en), .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
    .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
    .id_status(id_status), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .hazard_stall(s_stall), .exe_valid(s_valid), .exe_pc(s_pc),
    .exe_val_rn(s_val_rn), .exe_val_rm(s_val_rm), .exe_src1(s_src1),
    .exe_src2(s_src2), .exe_dest(s_dest), .exe_exe_cmd(s_exe_cmd),
    .exe_mem_r_en(s_mem_r_en), .exe_mem_w_en(s_mem_w_en), .exe_wb_en(s_wb_en),
    .exe_b(s_b), .exe_s(s_s), .exe_imm(s_imm), .exe_shift_operand(s_shift_operand),
    .exe_signed_imm_24(s_signed_imm_24), .exe_status(s_status), .bubble_count(s_count)
  );

  typedef struct {
    bit two; bit v; logic [31:0] pc, rn, rm; logic [3:0] s1, s2, d, cmd;
    bit rd, wr, wb, b, s, imm; logic [11:0] sh; logic [23:0] off; logic [3:0] st;
  } ins_t;
  typedef struct { logic [158:0] ex; longint bub; } exp_t;

  ins_t m_exe;
  longint m_bub;
  bit stall_q[$];
  exp_t st_q[$];
  int checks = 0, passes = 0;

  function automatic logic [158:0] pack(ins_t i);
    return {i.v, i.pc, i.rn, i.rm, i.s1, i.s2, i.d, i.cmd, i.rd, i.wr, i.wb, i.b, i.s, i.imm, i.sh, i.off, i.st};
  endfunction

  function automatic ins_t bubble_ins();
    ins_t z;
    z.two = 0; z.v = 0; z.pc = 0; z.rn = 0; z.rm = 0; z.s1 = 0; z.s2 = 0; z.d = 0; z.cmd = 0;
    z.rd = 0; z.wr = 0; z.wb = 0; z.b = 0; z.s = 0; z.imm = 0; z.sh = 0; z.off = 0; z.st = 0;
    return z;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i.two = 1'($urandom); i.v = $urandom_range(0, 3) != 0;
    i.pc = $urandom; i.rn = $urandom; i.rm = $urandom;
    i.s1 = 4'($urandom_range(0, 3)); i.s2 = 4'($urandom_range(0, 3)); i.d = 4'($urandom_range(0, 3));
    i.cmd = 4'($urandom); i.rd = 1'($urandom); i.wr = 1'($urandom); i.wb = 1'($urandom);
    i.b = 1'($urandom); i.s = 1'($urandom); i.imm = 1'($urandom);
    i.sh = 12'($urandom); i.off = 24'($urandom); i.st = 4'($urandom);
    return i;
  endfunction

  function automatic ins_t mk(bit v, logic [3:0] s1, s2, bit two, logic [3:0] d, bit rd, wb);
    ins_t i = rnd_ins();
    i.v = v; i.s1 = s1; i.s2 = s2; i.two = two; i.d = d; i.rd = rd; i.wb = wb;
    return i;
  endfunction

  function automatic bit reads(ins_t i, logic [3:0] r);
    return r == i.s1 || (i.two && r == i.s2);
  endfunction

  function automatic longint sat(longint n, longint mx);
    return n > mx ? mx : n;
  endfunction

  task automatic check(string name, logic [158:0] got, logic [158:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic drive(ins_t i, bit fwd, bit fz, bit fl, logic [3:0] md, bit mwb);
    bit haz;
    @(posedge clk);
    #2;
    id_valid = i.v; id_pc = i.pc; id_val_rn = i.rn; id_val_rm = i.rm;
    id_src1 = i.s1; id_src2 = i.s2; id_dest = i.d; id_two_src = i.two; id_exe_cmd = i.cmd;
    id_mem_r_en = i.rd; id_mem_w_en = i.wr; id_wb_en = i.wb; id_b = i.b; id_s = i.s; id_imm = i.imm;
    id_shift_operand = i.sh; id_signed_imm_24 = i.off; id_status = i.st;
    forwarding_en = fwd; freeze = fz; flush = fl; mem_dest = md; mem_wb_en = mwb;
    if (fwd) haz = i.v && m_exe.v && m_exe.rd && reads(i, m_exe.d);
    else haz = i.v && ((m_exe.v && m_exe.wb && reads(i, m_exe.d)) || (mwb && reads(i, md)));
    stall_q.push_back(haz && !fl);
    if (!fz) begin
      if (fl || haz) begin
        m_exe = bubble_ins();
        if (!fl) m_bub++;
      end else m_exe = i;
    end
    st_q.push_back('{pack(m_exe), m_bub});
  endtask

  function automatic logic [158:0] dut_pack();
    return {exe_valid, exe_pc, exe_val_rn, exe_val_rm, exe_src1, exe_src2, exe_dest, exe_exe_cmd,
            exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s, exe_imm, exe_shift_operand,
            exe_signed_imm_24, exe_status};
  endfunction

  function automatic logic [158:0] sat_pack();
    return {s_valid, s_pc, s_val_rn, s_val_rm, s_src1, s_src2, s_dest, s_exe_cmd,
            s_mem_r_en, s_mem_w_en, s_wb_en, s_b, s_s, s_imm, s_shift_operand,
            s_signed_imm_24, s_status};
  endfunction

  always @(negedge clk) begin
    if (stall_q.size() > 0 && st_q.size() > 0) begin
      bit s;
      exp_t e;
      s = stall_q.pop_front();
      e = st_q.pop_front();
      check("hazard_stall", 159'(hazard_stall), 159'(s));
      check("hazard_stall_sat", 159'(s_stall), 159'(s));
      check("exe_fields", dut_pack(), e.ex);
      check("exe_fields_sat", sat_pack(), e.ex);
      check("bubble_count", 159'(bubble_count), 159'(sat(e.bub, 65535)));
      check("bubble_count_sat", 159'(s_count), 159'(sat(e.bub, 3)));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    ins_t ldr, use3, add5, sub5;
    m_exe = bubble_ins();
    m_bub = 0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_exe", dut_pack(), 159'(0));
    check("reset_count", 159'(bubble_count), 159'(0));
    check("reset_stall", 159'(hazard_stall), 159'(0));
    rst = 0;
    st_q.push_back('{pack(m_exe), m_bub});
    ldr = mk(1, 4'd1, 4'd2, 1, 4'd3, 1, 1);
    use3 = mk(1, 4'd3, 4'd9, 1, 4'd4, 0, 1);
    // load-use with forwarding: one bubble, then capture
    drive(ldr, 1, 0, 0, 0, 0);
    drive(use3, 1, 0, 0, 0, 0);
    drive(use3, 1, 0, 0, 0, 0);
    // src2 matches but instruction has a single source
    drive(ldr, 1, 0, 0, 0, 0);
    drive(mk(1, 4'd7, 4'd3, 0, 4'd4, 0, 1), 1, 0, 0, 0, 0);
    // no forwarding: EXE then MEM dependence, two bubbles
    add5 = mk(1, 4'd1, 4'd2, 1, 4'd5, 0, 1);
    sub5 = mk(1, 4'd5, 4'd6, 1, 4'd7, 0, 1);
    drive(add5, 0, 0, 0, 0, 0);
    drive(sub5, 0, 0, 0, 0, 0);
    drive(sub5, 0, 0, 0, 4'd5, 1);
    drive(sub5, 0, 0, 0, 4'd8, 0);
    // freeze while a hazard is pending
    drive(ldr, 1, 0, 0, 0, 0);
    repeat (3) drive(use3, 1, 1, 0, 0, 0);
    drive(use3, 1, 0, 0, 0, 0);
    drive(use3, 1, 0, 0, 0, 0);
    // flush beats hazard
    drive(ldr, 1, 0, 0, 0, 0);
    drive(use3, 1, 0, 1, 0, 0);
    drive(mk(1, 4'd0, 4'd0, 0, 4'd0, 0, 1), 0, 0, 0, 4'd0, 1);
    for (int n = 0; n < 1500; n++)
      drive(rnd_ins(), 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            4'($urandom_range(0, 3)), 1'($urandom));
    drive(mk(0, 4'd0, 4'd0, 0, 4'd0, 0, 0), 1, 0, 0, 0, 0);
    drive(mk(1, 4'd1, 4'd2, 1, 4'd6, 0, 1), 1, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    check("pre_rst_exe", dut_pack(), pack(m_exe));
    check("pre_rst_count", 159'(bubble_count), 159'(sat(m_bub, 65535)));
    rst = 1;
    #1;
    check("async_rst_exe", dut_pack(), 159'(0));
    check("async_rst_exe_sat", sat_pack(), 159'(0));
    check("async_rst_count", 159'(bubble_count), 159'(0));
    check("async_rst_count_sat", 159'(s_count), 159'(0));
    check("queue_drained", 159'(stall_q.size()), 159'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/id_exe_stage_reg.md
# id_exe_stage_reg

ID/EXE pipeline boundary of the ARM core. Captures the decoded instruction from the ID stage, registers `src1`/`src2` and the control bits consumed by the forwarding unit and EXE stage, and contains the load-use/RAW hazard interlock. When a hazard is detected, it inserts a bubble and stalls IF/ID. It honours the global memory freeze and the branch flush.

## Interface
Parameters:
- `DW`, 32, datapath width (PC, Rn, Rm values)
- `CNT_W`, 16, width of hazard bubble counter

Ports:
- `clk`  in  1  core clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `freeze`  in  1  memory-controller stall; hold all state
- `flush`  in  1  branch taken in EXE; kill the instruction being captured
- `forwarding_en`  in  1  forwarding enabled; selects interlock rule
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`, `id_val_rn`, `id_val_rm`  in  DW each  PC+4, Rn value, Rm value
- `id_src1`, `id_src2`, `id_dest`  in  4 each  register numbers
- `id_two_src`  in  1  instruction reads `src2`
- `id_exe_cmd`  in  4  ALU command
- `id_mem_r_en`, `id_mem_w_en`, `id_wb_en`, `id_b`, `id_s`, `id_imm`  in  1 each  control bits
- `id_shift_operand`  in  12  shifter operand
- `id_signed_imm_24`  in  24  branch offset
- `id_status`  in  4  NZCV snapshot
- `mem_dest`  in  4  destination register of the MEM-stage instruction
- `mem_wb_en`  in  1  write-back enable of the MEM-stage instruction
- `hazard_stall`  out  1  hold PC and IF/ID this cycle
- `exe_*`  out  same widths as `id_*` (valid, pc, val_rn, val_rm, src1, src2, dest, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, imm, shift_operand, signed_imm_24, status)  registered copies
- `bubble_count`  out  CNT_W  saturating count of hazard bubbles

## Operation
- Hazard check applies only when `id_valid` = 1.
  - An instruction "uses src1" always. It "uses src2" only when `id_two_src` = 1.
- With `forwarding_en` = 1, raise a hazard only on load-use:
  - `exe_valid` & `exe_mem_r_en` & `exe_dest` matches a used source.
- With `forwarding_en` = 0, raise a hazard when either of the following matches a used source:
  - `exe_valid` & `exe_wb_en` & `exe_dest`
  - `mem_wb_en` & `mem_dest`
  - The register file writes on the falling edge, so the WB stage needs no check.
- `hazard_stall` = hazard & ~`flush`. It is not gated by `freeze`.
- Register update priority at the rising edge:
  1. `rst` asserted: asynchronously clear all `exe_*` and `bubble_count` to 0.
  2. `freeze` = 1: hold all registers, including `bubble_count`.
  3. `flush` = 1: load a bubble.
  4. Hazard: load a bubble and increment `bubble_count`, saturating at 2^CNT_W−1.
  5. Otherwise: capture all `id_*`, with `exe_valid` = `id_valid`.
- Bubble: every `exe_*` field is 0, so `wb_en`, `mem_r_en`, `mem_w_en`, `b` and `s` are all 0.
- A source or destination value of 0 still compares; R0 is not special.

## Timing
- Latency: `id_*` to `exe_*` takes 1 cycle.
- `hazard_stall` is combinational from the current `id_*` and registered `exe_*` in the same cycle. It has no reset state, but evaluates to 0 after reset because `exe_valid` = 0.
- A load-use hazard with forwarding costs exactly 1 bubble. Next cycle the load is in MEM and the forwarding unit supplies the value.
- Without forwarding, a dependence on the EXE-stage instruction costs 2 bubbles. A dependence on the MEM-stage instruction costs 1.
- During `freeze`, the stall persists across frozen cycles. No bubble is inserted or counted until `freeze` drops.
- `flush` and hazard together: flush wins. `hazard_stall` = 0 and the counter does not increment.
- `rst` mid-operation: outputs clear immediately, with no clock edge required.

## Structure
- Shared package `arm_pkg`:
  - `EXE_CMD_W` = 4 and register-number width 4
  - the forwarding select constants (ID/WB/MEM)
  - a packed `id_exe_t` struct of all captured fields, so the register is a single struct flop
- Sub-module `hazard_detect`: purely combinational; inputs are the sources, `two_src`, EXE/MEM destination info and `forwarding_en`; output is the hazard flag.
- The flop, priority logic and counter stay in the top module.

## Test plan
- Load-use with forwarding: EXE holds `ldr` with dest R3; ID presents `add` with src1 = 3. Expect `hazard_stall` = 1, a bubble next cycle, `bubble_count` = 1, then `add` captured on the following cycle.
- Same scenario with `id_two_src` = 0 and a match on src2 = 3 only: expect no stall and `add` captured next cycle.
- Forwarding off: EXE `add` writes R5; ID `sub` reads R5. Expect 2 consecutive stall cycles, `bubble_count` = 2, then capture.
- Freeze during a hazard: `freeze` = 1 for 3 cycles. Expect `exe_*` held and `bubble_count` unchanged; after release, 1 bubble.
- `flush` and hazard in the same cycle: expect `hazard_stall` = 0, `exe_valid` = 0, `bubble_count` unchanged.
- Assert `rst` asynchronously mid-stream with `exe_wb_en` = 1: expect all `exe_*` = 0 and `bubble_count` = 0 before the next edge. Separately, saturation: with CNT_W = 2 and 5 bubbles, expect `bubble_count` = 3.
